// File: rtl/lstm_gate_mac.sv
// lstm_gate_mac: gate pre-activation accumulator for the LSTM accelerator.
//
// Consumes the packed word stream from the register controller. Weight words
// (four int8 gate weights each) fill a per-unit buffer. An operand word then
// multiplies every buffered weight by the operand value and accumulates the
// result into the four gate accumulators of each unit, one unit per cycle.
// Bias words add directly into the accumulators. After the operand flagged
// last, all 4*NUM_UNITS accumulators are streamed out unit-major, gate-minor.
//
// Ports:
//   clk, rst         clock, asynchronous active-low reset
//   in_valid/ready   input word handshake
//   in_data          byte0=f, byte1=i, byte2=o, byte3=c~ (operand uses byte0)
//   in_kind          0=weight, 1=operand, 2=bias, 3=reserved
//   in_last          last operand of the timestep (sampled with operand)
//   out_valid/ready  accumulator output handshake
//   out_data         saturated signed accumulator value
//   out_unit/gate    unit index and gate (0=f,1=i,2=o,3=c~) of out_data
//   step_done        one-cycle pulse after the final drain handshake
//   err              sticky protocol error, cleared only by reset
//
// NUM_UNITS must be at least 2.
module lstm_gate_mac #(
    parameter int NUM_UNITS = 32,
    parameter int ACC_W     = 24
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [31:0]                   in_data,
    input  logic [1:0]                    in_kind,
    input  logic                          in_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [ACC_W-1:0]       out_data,
    output logic [$clog2(NUM_UNITS)-1:0]  out_unit,
    output logic [1:0]                    out_gate,
    output logic                          step_done,
    output logic                          err
);

    localparam int UW = $clog2(NUM_UNITS);
    localparam int PW = $clog2(NUM_UNITS + 1);
    localparam logic [PW-1:0] NU_P   = PW'(NUM_UNITS);
    localparam logic [UW-1:0] LAST_U = UW'(NUM_UNITS - 1);
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_MAC   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Saturating signed add: one guard bit detects overflow of the ACC_W sum.
    function automatic logic signed [ACC_W-1:0] sat_add(
        input logic signed [ACC_W-1:0] a,
        input logic signed [ACC_W-1:0] b
    );
        logic signed [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        if (s[ACC_W] != s[ACC_W-1]) begin
            sat_add = s[ACC_W] ? ACC_MIN : ACC_MAX;
        end else begin
            sat_add = s[ACC_W-1:0];
        end
    endfunction

    state_t                  state_r;
    logic [PW-1:0]           wptr_r;
    logic [PW-1:0]           bptr_r;
    logic signed [7:0]       wbuf_r [NUM_UNITS][4];
    logic signed [ACC_W-1:0] acc_r  [NUM_UNITS][4];
    logic signed [7:0]       x_r;
    logic                    last_r;
    logic [UW-1:0]           mac_k_r;
    logic                    in_ready_r;
    logic                    out_valid_r;
    logic signed [ACC_W-1:0] out_data_r;
    logic [UW-1:0]           out_unit_r;
    logic [1:0]              out_gate_r;
    logic                    step_done_r;
    logic                    err_r;

    logic signed [15:0]      prod_s     [4];
    logic signed [ACC_W-1:0] mac_sum_s  [4];
    logic signed [ACC_W-1:0] bias_sum_s [4];
    logic [UW-1:0]           bidx_s;
    logic [UW-1:0]           nxt_unit_s;
    logic [1:0]              nxt_gate_s;
    logic                    drain_end_s;

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_unit  = out_unit_r;
    assign out_gate  = out_gate_r;
    assign step_done = step_done_r;
    assign err       = err_r;

    // Per-gate MAC and bias sums, plus the next drain index.
    always_comb begin
        bidx_s = bptr_r[UW-1:0];
        for (int g = 0; g < 4; g++) begin
            prod_s[g]     = 16'(wbuf_r[mac_k_r][g]) * 16'(x_r);
            mac_sum_s[g]  = sat_add(acc_r[mac_k_r][g], ACC_W'(prod_s[g]));
            bias_sum_s[g] = sat_add(acc_r[bidx_s][g], ACC_W'($signed(in_data[8*g +: 8])));
        end
        drain_end_s = (out_unit_r == LAST_U) && (out_gate_r == 2'd3);
        if (out_gate_r == 2'd3) begin
            nxt_unit_s = out_unit_r + UW'(1);
            nxt_gate_s = 2'd0;
        end else begin
            nxt_unit_s = out_unit_r;
            nxt_gate_s = out_gate_r + 2'd1;
        end
    end

    // Control FSM, weight buffer, accumulators and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_LOAD;
            wptr_r      <= '0;
            bptr_r      <= '0;
            x_r         <= 8'sd0;
            last_r      <= 1'b0;
            mac_k_r     <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_unit_r  <= '0;
            out_gate_r  <= 2'd0;
            step_done_r <= 1'b0;
            err_r       <= 1'b0;
            for (int u = 0; u < NUM_UNITS; u++) begin
                for (int g = 0; g < 4; g++) begin
                    wbuf_r[u][g] <= 8'sd0;
                    acc_r[u][g]  <= '0;
                end
            end
        end else begin
            step_done_r <= 1'b0;
            case (state_r)
                ST_LOAD: begin
                    if (in_valid && in_ready_r) begin
                        case (in_kind)
                            2'd0: begin
                                if (wptr_r < NU_P) begin
                                    for (int g = 0; g < 4; g++) begin
                                        wbuf_r[wptr_r[UW-1:0]][g] <= in_data[8*g +: 8];
                                    end
                                    wptr_r <= wptr_r + PW'(1);
                                end else begin
                                    err_r <= 1'b1;
                                end
                            end
                            2'd1: begin
                                if (wptr_r == NU_P) begin
                                    x_r        <= in_data[7:0];
                                    last_r     <= in_last;
                                    mac_k_r    <= '0;
                                    in_ready_r <= 1'b0;
                                    state_r    <= ST_MAC;
                                end else begin
                                    err_r <= 1'b1;
                                end
                            end
                            2'd2: begin
                                if (bptr_r < NU_P) begin
                                    for (int g = 0; g < 4; g++) begin
                                        acc_r[bidx_s][g] <= bias_sum_s[g];
                                    end
                                    bptr_r <= bptr_r + PW'(1);
                                end else begin
                                    err_r <= 1'b1;
                                end
                            end
                            default: err_r <= 1'b1;
                        endcase
                    end
                end
                ST_MAC: begin
                    for (int g = 0; g < 4; g++) begin
                        acc_r[mac_k_r][g] <= mac_sum_s[g];
                    end
                    mac_k_r <= mac_k_r + UW'(1);
                    if (mac_k_r == LAST_U) begin
                        wptr_r <= '0;
                        if (last_r) begin
                            // Unit 0 finished earlier in this pass, so its f value is final.
                            state_r     <= ST_DRAIN;
                            out_valid_r <= 1'b1;
                            out_data_r  <= acc_r[0][0];
                            out_unit_r  <= '0;
                            out_gate_r  <= 2'd0;
                        end else begin
                            state_r    <= ST_LOAD;
                            in_ready_r <= 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (out_ready) begin
                        if (drain_end_s) begin
                            for (int u = 0; u < NUM_UNITS; u++) begin
                                for (int g = 0; g < 4; g++) begin
                                    acc_r[u][g] <= '0;
                                end
                            end
                            bptr_r      <= '0;
                            wptr_r      <= '0;
                            out_valid_r <= 1'b0;
                            out_data_r  <= '0;
                            out_unit_r  <= '0;
                            out_gate_r  <= 2'd0;
                            step_done_r <= 1'b1;
                            in_ready_r  <= 1'b1;
                            state_r     <= ST_LOAD;
                        end else begin
                            out_data_r <= acc_r[nxt_unit_s][nxt_gate_s];
                            out_unit_r <= nxt_unit_s;
                            out_gate_r <= nxt_gate_s;
                        end
                    end
                end
                default: begin
                    state_r     <= ST_LOAD;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lstm_gate_mac.sv
// Self-checking bench for lstm_gate_mac (NUM_UNITS=2, ACC_W=17).
// A behavioural model tracks weights, biases and accumulators with plain
// integer arithmetic and queues the expected drain values.
module tb_lstm_gate_mac;

    localparam int N  = 2;
    localparam int AW = 17;

    logic                 clk;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          in_data;
    logic [1:0]           in_kind;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [AW-1:0] out_data;
    logic [0:0]           out_unit;
    logic [1:0]           out_gate;
    logic                 step_done;
    logic                 err;

    lstm_gate_mac #(.NUM_UNITS(N), .ACC_W(AW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_kind(in_kind), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_unit(out_unit), .out_gate(out_gate),
        .step_done(step_done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int ref_acc [N][4];
    int ref_w   [N][4];
    int ref_wptr;
    int ref_bptr;
    bit ref_err;
    int exp_q [$];

    function automatic int s8(input logic [7:0] b);
        return int'($signed(b));
    endfunction

    function automatic int clamp(input int v);
        int hi, lo;
        hi = (1 << (AW - 1)) - 1;
        lo = -(1 << (AW - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    task automatic model_clear();
        for (int u = 0; u < N; u++)
            for (int g = 0; g < 4; g++) begin
                ref_acc[u][g] = 0;
                ref_w[u][g]   = 0;
            end
        ref_wptr = 0;
        ref_bptr = 0;
        ref_err  = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_word(input logic [1:0] kind, input logic [31:0] d, input logic last);
        int x;
        case (kind)
            2'd0: if (ref_wptr < N) begin
                      for (int g = 0; g < 4; g++) ref_w[ref_wptr][g] = s8(d[8*g +: 8]);
                      ref_wptr++;
                  end else ref_err = 1'b1;
            2'd2: if (ref_bptr < N) begin
                      for (int g = 0; g < 4; g++)
                          ref_acc[ref_bptr][g] = clamp(ref_acc[ref_bptr][g] + s8(d[8*g +: 8]));
                      ref_bptr++;
                  end else ref_err = 1'b1;
            2'd1: if (ref_wptr == N) begin
                      x = s8(d[7:0]);
                      for (int u = 0; u < N; u++)
                          for (int g = 0; g < 4; g++)
                              ref_acc[u][g] = clamp(ref_acc[u][g] + ref_w[u][g] * x);
                      ref_wptr = 0;
                      if (last) begin
                          for (int u = 0; u < N; u++)
                              for (int g = 0; g < 4; g++) begin
                                  exp_q.push_back(ref_acc[u][g]);
                                  ref_acc[u][g] = 0;
                              end
                          ref_bptr = 0;
                      end
                  end else ref_err = 1'b1;
            default: ref_err = 1'b1;
        endcase
    endtask

    task automatic send_word(input logic [1:0] kind, input logic [31:0] d, input logic last);
        int t = 0;
        in_valid = 1'b1; in_kind = kind; in_data = d; in_last = last;
        while (in_ready !== 1'b1 && t < 100) begin
            @(posedge clk); #1; t++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_word_timeout: in_ready=%b required 1 within 100 cycles", in_ready);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        model_word(kind, d, last);
    endtask

    task automatic do_reset();
        in_valid = 1'b0; out_ready = 1'b0;
        rst = 1'b0;
        #2;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0 || out_unit !== 1'b0 ||
            out_gate !== 2'd0 || step_done !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: rdy=%b ov=%b data=%0d unit=%0d gate=%0d sd=%b err=%b required 1 0 0 0 0 0 0",
                     in_ready, out_valid, out_data, out_unit, out_gate, step_done, err);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        model_clear();
    endtask

    // mode 0: ready always; 1: pattern 1,0,0,1; 2: random. Stops after max_xfer transfers.
    task automatic drain_check(input int mode, input int max_xfer, input bit timing);
        int got = 0, cyc = 0, exp_v, sd_count = 0;
        bit stall_prev = 1'b0;
        logic signed [AW-1:0] pd;
        logic [0:0] pu;
        logic [1:0] pg;
        while (got < max_xfer && cyc < 400) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (step_done === 1'b1) sd_count++;
            if (stall_prev) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== pd || out_unit !== pu || out_gate !== pg) begin
                    errors++;
                    $display("FAIL stall_stable: v=%b data=%0d u=%0d g=%0d required 1 %0d %0d %0d",
                             out_valid, out_data, out_unit, out_gate, pd, pu, pg);
                end
            end
            if (out_valid === 1'b1 && out_ready) begin
                exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 0;
                checks++;
                if (int'(out_data) !== exp_v || int'(out_unit) !== got / 4 || int'(out_gate) !== got % 4) begin
                    errors++;
                    $display("FAIL drain_word%0d: data=%0d u=%0d g=%0d required %0d %0d %0d",
                             got, out_data, out_unit, out_gate, exp_v, got / 4, got % 4);
                end
                got++;
            end
            stall_prev = (out_valid === 1'b1) && !out_ready;
            pd = out_data; pu = out_unit; pg = out_gate;
            @(posedge clk); #1;
            cyc++;
        end
        out_ready = 1'b0;
        checks++;
        if (got < max_xfer) begin
            errors++;
            $display("FAIL drain_timeout: transfers=%0d required %0d", got, max_xfer);
            return;
        end
        if (max_xfer < 4 * N) return;
        checks++;
        if (step_done !== 1'b1 || in_ready !== 1'b1 || out_valid !== 1'b0 || err !== ref_err || sd_count != 0) begin
            errors++;
            $display("FAIL drain_end: sd=%b rdy=%b ov=%b err=%b early_sd=%0d required 1 1 0 %b 0",
                     step_done, in_ready, out_valid, err, sd_count, ref_err);
        end
        if (timing) begin
            checks++;
            if (cyc != 5 * N) begin
                errors++;
                $display("FAIL drain_latency: cycles=%0d required %0d", cyc, 5 * N);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (step_done !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL step_done_pulse: sd=%b ov=%b required 0 0", step_done, out_valid);
        end
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_basic();
        send_word(2'd2, 32'h04030201, 1'b0);
        send_word(2'd2, 32'h04030201, 1'b0);
        send_word(2'd0, 32'h04030201, 1'b0);
        send_word(2'd0, 32'hFCFDFEFF, 1'b0);
        send_word(2'd1, 32'h00000003, 1'b1);
        exp_q = '{4, 8, 12, 16, -2, -4, -6, -8};
        drain_check(0, 4 * N, 1'b1);
    endtask

    task automatic test_two_groups();
        send_word(2'd0, 32'h7F7F7F7F, 1'b0);
        send_word(2'd0, 32'h7F7F7F7F, 1'b0);
        send_word(2'd1, 32'h00000002, 1'b0);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL mac_busy%0d: rdy=%b ov=%b required 0 0", i, in_ready, out_valid);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mac_return: rdy=%b ov=%b required 1 0", in_ready, out_valid);
        end
        send_word(2'd0, 32'h7F7F7F7F, 1'b0);
        send_word(2'd0, 32'h7F7F7F7F, 1'b0);
        send_word(2'd1, 32'h000000FF, 1'b1);
        drain_check(0, 4 * N, 1'b1);
    endtask

    task automatic test_saturation();
        for (int r = 0; r < 5; r++) begin
            send_word(2'd0, 32'h80808080, 1'b0);
            send_word(2'd0, 32'h7F7F7F7F, 1'b0);
            send_word(2'd1, 32'h00000080, (r == 4));
        end
        drain_check(0, 4 * N, 1'b1);
    endtask

    task automatic test_backpressure();
        send_word(2'd2, $urandom, 1'b0);
        send_word(2'd0, $urandom, 1'b0);
        send_word(2'd0, $urandom, 1'b0);
        send_word(2'd1, $urandom, 1'b1);
        drain_check(1, 4 * N, 1'b0);
    endtask

    task automatic test_protocol_errors();
        do_reset();
        send_word(2'd0, $urandom, 1'b0);
        send_word(2'd1, 32'h00000005, 1'b1);
        checks++;
        if (err !== 1'b1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL early_operand_err: err=%b rdy=%b required 1 1", err, in_ready);
        end
        send_word(2'd0, $urandom, 1'b0);
        send_word(2'd0, 32'h01010101, 1'b0);
        send_word(2'd3, $urandom, 1'b0);
        send_word(2'd1, $urandom, 1'b1);
        drain_check(0, 4 * N, 1'b1);
        do_reset();
        send_word(2'd0, 32'h01020304, 1'b0);
        send_word(2'd0, 32'h05060708, 1'b0);
        send_word(2'd0, 32'h7F7F7F7F, 1'b0);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL third_weight_err: err=%b required 1", err);
        end
        send_word(2'd1, 32'h000000FE, 1'b1);
        drain_check(0, 4 * N, 1'b1);
    endtask

    task automatic test_reset_drain();
        send_word(2'd2, $urandom, 1'b0);
        send_word(2'd0, $urandom, 1'b0);
        send_word(2'd0, $urandom, 1'b0);
        send_word(2'd1, $urandom, 1'b1);
        drain_check(0, 3, 1'b0);
        do_reset();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_drain: ov=%b rdy=%b required 0 1", out_valid, in_ready);
        end
        send_word(2'd0, $urandom, 1'b0);
        send_word(2'd0, $urandom, 1'b0);
        send_word(2'd1, $urandom, 1'b1);
        drain_check(2, 4 * N, 1'b0);
    endtask

    task automatic test_random();
        int groups;
        do_reset();
        for (int s = 0; s < 4; s++) begin
            groups = $urandom_range(1, 3);
            for (int gi = 0; gi < groups; gi++) begin
                for (int w = 0; w < N; w++) begin
                    if (ref_bptr < N && $urandom_range(0, 2) == 0) send_word(2'd2, $urandom, 1'b0);
                    send_word(2'd0, $urandom, 1'b0);
                end
                send_word(2'd1, $urandom, (gi == groups - 1));
            end
            drain_check(2, 4 * N, 1'b0);
        end
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_data = 32'd0; in_kind = 2'd0;
        in_last = 1'b0; out_ready = 1'b0;
        model_clear();
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_two_groups();
        test_saturation();
        test_backpressure();
        test_protocol_errors();
        test_reset_drain();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
